// File: rtl/seq_divider8_pkg.sv
// Shared types for the sequential divider: FSM states and
// active-low 7-seg patterns (gfedcba) with a hex decoder.
package seq_divider8_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [6:0] SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic logic [6:0] hex7seg(input logic [3:0] nib);
    return SEG[nib];
  endfunction

endpackage

// File: rtl/seq_divider8_div_step.sv
// One restoring-division step: shift the next dividend bit
// into R, subtract D when it fits, and emit the quotient bit.
module seq_divider8_div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] r,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic             q_bit
);

  logic [WIDTH:0]   r_sh;
  logic [WIDTH-1:0] diff;

  assign r_sh = {r, bit_in};
  // Compare is one bit wider than the operands so a shifted-out
  // MSB still counts. When it fits, the true difference is below
  // D, so the low WIDTH bits of the modular subtract are exact.
  assign q_bit  = (r_sh >= {1'b0, d});
  assign diff   = r_sh[WIDTH-1:0] - d;
  assign r_next = q_bit ? diff : r_sh[WIDTH-1:0];

endmodule

// File: rtl/seq_divider8.sv
// Multi-cycle restoring divider, one quotient bit per clock,
// with 7-seg result displays. Define DIV_SIGNED_EN for signed.
module seq_divider8
  import seq_divider8_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow,
  output logic [6:0]       qH,
  output logic [6:0]       qL,
  output logic [6:0]       rH,
  output logic [6:0]       rL
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state, next_state;

  logic [WIDTH-1:0] r_q, q_q, d_q;
  logic [CW-1:0]    count;
  logic             neg_q, neg_r, ovf_q, dbz_q;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             sgn_q_in, sgn_r_in, ovf_in;
  logic [WIDTH-1:0] step_r;
  logic             step_bit;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic             zero_div;

`ifdef DIV_SIGNED_EN
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  assign a_mag    = dividend[WIDTH-1] ? -dividend : dividend;
  assign b_mag    = divisor[WIDTH-1] ? -divisor : divisor;
  assign sgn_q_in = dividend[WIDTH-1] ^ divisor[WIDTH-1];
  assign sgn_r_in = dividend[WIDTH-1];
  assign ovf_in   = (dividend == MIN_NEG) && (&divisor);
`else
  assign a_mag    = dividend;
  assign b_mag    = divisor;
  assign sgn_q_in = 1'b0;
  assign sgn_r_in = 1'b0;
  assign ovf_in   = 1'b0;
`endif

  assign zero_div = (divisor == '0);
  assign busy     = (state != IDLE);
  assign q_fix    = neg_q ? -q_q : q_q;
  assign r_fix    = neg_r ? -r_q : r_q;

  seq_divider8_div_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_q),
    .bit_in (q_q[WIDTH-1]),
    .d      (d_q),
    .r_next (step_r),
    .q_bit  (step_bit)
  );

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state: zero divisor skips the iteration entirely
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (start) next_state = zero_div ? DONE : CALC;
      CALC: if (count == LAST) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand capture, iteration and result write-back
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      count       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            r_q   <= '0;
            q_q   <= zero_div ? dividend : a_mag;
            d_q   <= b_mag;
            count <= '0;
            neg_q <= sgn_q_in;
            neg_r <= sgn_r_in;
            ovf_q <= ovf_in;
            dbz_q <= zero_div;
          end
        end
        CALC: begin
          r_q   <= step_r;
          q_q   <= {q_q[WIDTH-2:0], step_bit};
          count <= count + 1'b1;
        end
        DONE: begin
          done <= 1'b1;
          if (dbz_q) begin
            quotient    <= '1;
            remainder   <= q_q;
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
          end else begin
            quotient    <= q_fix;
            remainder   <= r_fix;
            div_by_zero <= 1'b0;
            overflow    <= ovf_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign qH = hex7seg(quotient[7:4]);
  assign qL = hex7seg(quotient[3:0]);
  assign rH = hex7seg(remainder[7:4]);
  assign rL = hex7seg(remainder[3:0]);

endmodule

// File: tb/tb_seq_divider8.sv
// Directed bench for seq_divider8: expected results queued at
// launch, popped and compared when done pulses.
module tb_seq_divider8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic       busy, done, div_by_zero, overflow;
  logic [7:0] quotient, remainder;
  logic [6:0] qH, qL, rH, rL;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  seq_divider8 #(.WIDTH(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow),
    .qH          (qH),
    .qL          (qL),
    .rH          (rH),
    .rL          (rL)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a,
                                 input logic [7:0] b);
    exp_t e;
`ifdef DIV_SIGNED_EN
    int sa, sb_, sq, sr;
`endif
    e = '0;
    if (b == 8'h00) begin
      e.q   = 8'hFF;
      e.r   = a;
      e.dbz = 1'b1;
    end
`ifdef DIV_SIGNED_EN
    else if (a == 8'h80 && b == 8'hFF) begin
      e.q   = 8'h80;
      e.r   = 8'h00;
      e.ovf = 1'b1;
    end else begin
      sa  = int'($signed(a));
      sb_ = int'($signed(b));
      sq  = sa / sb_;
      sr  = sa % sb_;
      e.q = sq[7:0];
      e.r = sr[7:0];
    end
`else
    else begin
      e.q = a / b;
      e.r = a % b;
    end
`endif
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after E0.
  task automatic launch(input logic [7:0] a, input logic [7:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back(model(a, b));
    @(negedge clock);
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
  endtask

  task automatic wait_done(input int exp_lat, input string tag);
    int n = 0;
    int busy_n = 0;
    exp_t e;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) busy_n++;
      @(negedge clock);
      n++;
    end
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_busy_cycles"}, busy_n, exp_lat);
    check({tag, "_busy_low_at_done"}, busy, 0);
    if (sb.size() == 0) begin
      check({tag, "_sb_nonempty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      if (done === 1'b1) begin
        check({tag, "_quotient"}, quotient, e.q);
        check({tag, "_remainder"}, remainder, e.r);
        check({tag, "_div_by_zero"}, div_by_zero, e.dbz);
        check({tag, "_overflow"}, overflow, e.ovf);
      end
    end
  endtask

  task automatic no_done(input int cycles, input string tag);
    int extra = 0;
    repeat (cycles) begin
      @(negedge clock);
      if (done === 1'b1) extra++;
    end
    check(tag, extra, 0);
  endtask

  initial begin
    #2 reset = 1'b0;
    @(negedge clock);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_ovf", overflow, 0);
    check("rst_qH", qH, 7'b1000000);
    check("rst_qL", qL, 7'b1000000);
    check("rst_rH", rH, 7'b1000000);
    check("rst_rL", rL, 7'b1000000);
    reset = 1'b1;
    @(negedge clock);

    launch(8'd200, 8'd7);
    wait_done(9, "t1");
    check("t1_qH", qH, 7'b1111001);
    check("t1_qL", qL, 7'b1000110);
    check("t1_rH", rH, 7'b1000000);
    check("t1_rL", rL, 7'b0011001);
    @(negedge clock);
    check("t1_done_one_cycle", done, 0);

    launch(8'd255, 8'd1);
    wait_done(9, "t2a");
    launch(8'd3, 8'd200);
    wait_done(9, "t2b");

    launch(8'd5, 8'd0);
    wait_done(1, "t3a");
    launch(8'd9, 8'd3);
    wait_done(9, "t3b");

    launch(8'd200, 8'd7);
    repeat (2) @(negedge clock);
    dividend = 8'd10;
    divisor  = 8'd2;
    start    = 1'b1;
    @(negedge clock);
    start    = 1'b0;
    wait_done(6, "t4a");
    no_done(15, "t4a_no_extra_done");

    dividend = 8'd50;
    divisor  = 8'd5;
    start    = 1'b1;
    sb.push_back(model(8'd50, 8'd5));
    @(negedge clock);
    wait_done(9, "t4b");
    dividend = 8'd100;
    divisor  = 8'd7;
    sb.push_back(model(8'd100, 8'd7));
    @(negedge clock);
    start = 1'b0;
    wait_done(9, "t4c");

    launch(8'd100, 8'd3);
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("t5_quotient", quotient, 0);
    check("t5_remainder", remainder, 0);
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_qL", qL, 7'b1000000);
    check("t5_rL", rL, 7'b1000000);
    void'(sb.pop_back());
    @(negedge clock);
    reset = 1'b1;
    no_done(12, "t5_no_done");
    launch(8'd100, 8'd10);
    wait_done(9, "t5");

    launch(8'hF9, 8'd2);
    wait_done(9, "t6a");
    launch(8'h80, 8'hFF);
    wait_done(9, "t6b");
    launch(8'd7, 8'hFE);
    wait_done(9, "t6c");

    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
